// File: rtl/axi_st_pkg.sv
// Shared AXI-Stream definitions: the FSM state names (common to the master and
// slave endpoints) and the default data/length widths.
package axi_st_pkg;

  localparam int AXI_DATA_W = 32;
  localparam int AXI_LEN_W  = 8;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    STREAM = 2'd1,
    GAP    = 2'd2
  } axi_st_state_e;

endpackage

// File: rtl/axi_stream_master.sv
// AXI-Stream transmit endpoint. A command (len, seed) starts a packet of len+1
// beats carrying seed, seed+1, ... under m_tready backpressure. After the last
// beat, an optional idle gap is inserted before the next command is taken.
// Every output comes straight from a flop.
module axi_stream_master
  import axi_st_pkg::*;
#(
  parameter int DATA_W     = AXI_DATA_W,
  parameter int LEN_W      = AXI_LEN_W,
  parameter int GAP_CYCLES = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [LEN_W-1:0]  cmd_len,
  input  logic [DATA_W-1:0] cmd_seed,
  output logic              m_tvalid,
  input  logic              m_tready,
  output logic [DATA_W-1:0] m_tdata,
  output logic              m_tlast,
  output logic              busy,
  output logic              pkt_done
);

  // The gap counter only has to reach GAP_CYCLES-1; keep at least one bit so
  // the GAP_CYCLES=0 build still elaborates (GAP is unreachable there).
  localparam int GAP_W    = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam int GAP_LAST = (GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0;

  axi_st_state_e     state_q;
  logic [LEN_W-1:0]  len_q;
  logic [DATA_W-1:0] seed_q;
  logic [LEN_W-1:0]  beat_cnt_q;
  logic [GAP_W-1:0]  gap_cnt_q;
  logic              cmd_ready_q;
  logic              m_tvalid_q;
  logic [DATA_W-1:0] m_tdata_q;
  logic              m_tlast_q;
  logic              busy_q;
  logic              pkt_done_q;

  // Index of the beat that follows the one currently on the bus.
  logic [LEN_W-1:0]  beat_nxt_d;
  logic              hs_d;

  // Next beat index and the handshake qualifier used by the FSM.
  always_comb begin
    beat_nxt_d = beat_cnt_q + LEN_W'(1);
    hs_d       = m_tvalid_q && m_tready;
  end

  // Packet FSM with registered outputs. Beat payload is precomputed one
  // cycle ahead, so back-to-back handshakes need no bubble.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      len_q       <= '0;
      seed_q      <= '0;
      beat_cnt_q  <= '0;
      gap_cnt_q   <= '0;
      cmd_ready_q <= 1'b0;
      m_tvalid_q  <= 1'b0;
      m_tdata_q   <= '0;
      m_tlast_q   <= 1'b0;
      busy_q      <= 1'b0;
      pkt_done_q  <= 1'b0;
    end else begin
      pkt_done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          cmd_ready_q <= 1'b1;
          busy_q      <= 1'b0;
          if (cmd_valid && cmd_ready_q) begin
            len_q       <= cmd_len;
            seed_q      <= cmd_seed;
            beat_cnt_q  <= '0;
            m_tvalid_q  <= 1'b1;
            m_tdata_q   <= cmd_seed;
            m_tlast_q   <= (cmd_len == '0);
            cmd_ready_q <= 1'b0;
            busy_q      <= 1'b1;
            state_q     <= STREAM;
          end
        end
        STREAM: begin
          if (hs_d) begin
            if (m_tlast_q) begin
              m_tvalid_q <= 1'b0;
              m_tlast_q  <= 1'b0;
              pkt_done_q <= 1'b1;
              beat_cnt_q <= '0;
              if (GAP_CYCLES > 0) begin
                gap_cnt_q <= '0;
                state_q   <= GAP;
              end else begin
                cmd_ready_q <= 1'b1;
                busy_q      <= 1'b0;
                state_q     <= IDLE;
              end
            end else begin
              beat_cnt_q <= beat_nxt_d;
              // Wraps modulo 2**DATA_W by construction.
              m_tdata_q  <= seed_q + DATA_W'(beat_nxt_d);
              m_tlast_q  <= (beat_nxt_d == len_q);
            end
          end
        end
        GAP: begin
          if (gap_cnt_q == GAP_W'(GAP_LAST)) begin
            cmd_ready_q <= 1'b1;
            busy_q      <= 1'b0;
            state_q     <= IDLE;
          end else begin
            gap_cnt_q <= gap_cnt_q + GAP_W'(1);
          end
        end
        default: begin
          state_q     <= IDLE;
          m_tvalid_q  <= 1'b0;
          m_tlast_q   <= 1'b0;
          cmd_ready_q <= 1'b0;
          busy_q      <= 1'b0;
        end
      endcase
    end
  end

  assign cmd_ready = cmd_ready_q;
  assign m_tvalid  = m_tvalid_q;
  assign m_tdata   = m_tdata_q;
  assign m_tlast   = m_tlast_q;
  assign busy      = busy_q;
  assign pkt_done  = pkt_done_q;

endmodule
